// File: rtl/duty_btn_pkg.sv
// Shared types and widths for the duty-cycle button conditioner.
package duty_btn_pkg;

  localparam int unsigned CNT_W = 24;
  localparam int unsigned RPT_W = 32;

  typedef enum logic [1:0] {
    ST_RELEASED  = 2'd0,
    ST_PRESSING  = 2'd1,
    ST_PRESSED   = 2'd2,
    ST_RELEASING = 2'd3
  } btn_state_e;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchronizer, debounce FSM, press strobe.
// Optional auto-repeat timer when DUTY_BTN_AUTOREPEAT_EN is defined.
module debounce_channel
  import duty_btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic pulse_o,
  output logic held_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;
  logic             press_evt;
  logic             btn_s;

  assign btn_s = sync_q[1];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_evt = 1'b0;
    case (state_q)
      ST_RELEASED: begin
        if (btn_s) begin
          state_d = ST_PRESSING;
          cnt_d   = '0;
        end
      end
      ST_PRESSING: begin
        if (!btn_s) begin
          state_d = ST_RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = ST_PRESSED;
          cnt_d     = '0;
          press_evt = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_PRESSED: begin
        if (!btn_s) begin
          state_d = ST_RELEASING;
          cnt_d   = '0;
        end
      end
      ST_RELEASING: begin
        if (btn_s) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_RELEASED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef DUTY_BTN_AUTOREPEAT_EN
  localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0] rpt_q, rpt_d;
  logic             rpt_phase_q, rpt_phase_d;
  logic             rpt_fire;

  // Timer only runs while the channel stays PRESSED; any exit zeroes it.
  always_comb begin
    rpt_d       = '0;
    rpt_phase_d = 1'b0;
    rpt_fire    = 1'b0;
    if (state_q == ST_PRESSED && btn_s) begin
      rpt_phase_d = rpt_phase_q;
      if (rpt_q == (rpt_phase_q ? RPT_PERIOD_LAST : RPT_DELAY_LAST)) begin
        rpt_fire    = 1'b1;
        rpt_phase_d = 1'b1;
      end else begin
        rpt_d = rpt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rpt_q       <= '0;
      rpt_phase_q <= 1'b0;
    end else begin
      rpt_q       <= rpt_d;
      rpt_phase_q <= rpt_phase_d;
    end
  end

  assign pulse_d = press_evt | rpt_fire;
`else
  assign pulse_d = press_evt;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= '0;
      state_q <= ST_RELEASED;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;
  assign held_o  = (state_q == ST_PRESSED) || (state_q == ST_RELEASING);

endmodule

// File: rtl/duty_button_conditioner.sv
// Two debounced buttons driving inc/dec strobes for a PWM duty generator.
// Define DUTY_BTN_AUTOREPEAT_EN to enable held-button auto-repeat.
module duty_button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ui_increase_duty,
  input  logic       ui_decrease_duty,
  output logic       uo_inc_pulse,
  output logic       uo_dec_pulse,
  output logic [1:0] uo_held
);

  logic inc_p, dec_p;
  logic inc_held, dec_held;
  logic inc_pulse_q, dec_pulse_q;

  debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD)
  ) u_inc (
    .clk_i   (clk),
    .rst_i   (rst),
    .btn_i   (ui_increase_duty),
    .pulse_o (inc_p),
    .held_o  (inc_held)
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD)
  ) u_dec (
    .clk_i   (clk),
    .rst_i   (rst),
    .btn_i   (ui_decrease_duty),
    .pulse_o (dec_p),
    .held_o  (dec_held)
  );

  // Coincident strobes cancel each other; nothing is queued for later.
  always_ff @(posedge clk) begin
    if (rst) begin
      inc_pulse_q <= 1'b0;
      dec_pulse_q <= 1'b0;
    end else begin
      inc_pulse_q <= inc_p & ~dec_p;
      dec_pulse_q <= dec_p & ~inc_p;
    end
  end

  assign uo_inc_pulse = inc_pulse_q;
  assign uo_dec_pulse = dec_pulse_q;
  assign uo_held      = {dec_held, inc_held};

endmodule

// File: tb/tb_duty_button_conditioner.sv
// Table-driven bench for duty_button_conditioner (DEBOUNCE=4, DELAY=16, PERIOD=8).
module tb_duty_button_conditioner;

  localparam int unsigned DEB = 4;
  localparam int unsigned RD  = 16;
  localparam int unsigned RP  = 8;
`ifdef DUTY_BTN_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       inc;
  logic       dec;
  logic       uo_inc_pulse;
  logic       uo_dec_pulse;
  logic [1:0] uo_held;

  duty_button_conditioner #(
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .ui_increase_duty (inc),
    .ui_decrease_duty (dec),
    .uo_inc_pulse     (uo_inc_pulse),
    .uo_dec_pulse     (uo_dec_pulse),
    .uo_held          (uo_held)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst;
    logic       inc;
    logic       dec;
    logic       exp_inc;
    logic       exp_dec;
    logic [1:0] exp_held;
  } vec_t;

  vec_t        vecs[$];
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic add(input string nm, input logic r, input logic i, input logic d,
                     input logic ei, input logic ed, input logic [1:0] h);
    vec_t v;
    v.name = nm; v.rst = r; v.inc = i; v.dec = d;
    v.exp_inc = ei; v.exp_dec = ed; v.exp_held = h;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input int idx,
                       input logic ai, input logic ad, input logic [1:0] ah,
                       input logic ei, input logic ed, input logic [1:0] eh);
    n_vec++;
    if ({ai, ad, ah} !== {ei, ed, eh}) begin
      n_bad++;
      $display("FAIL %s[%0d]: got inc=%b dec=%b held=%b, expected inc=%b dec=%b held=%b",
               nm, idx, ai, ad, ah, ei, ed, eh);
    end
  endtask

  initial begin
    int lat;
    bit found;

    rst = 1'b1; inc = 1'b0; dec = 1'b0;

    for (int k = 0; k < 2; k++) add("reset", 1, 0, 0, 0, 0, 2'b00);
    // clean inc press: strobe 7 edges after first sampled 1
    for (int k = 0; k < 20; k++) add("inc_press", 0, 1, 0, k == 7, 0, k >= 6 ? 2'b01 : 2'b00);
    for (int k = 0; k < 8; k++)  add("inc_release", 0, 0, 0, 0, 0, k < 6 ? 2'b01 : 2'b00);
    for (int k = 0; k < 18; k++) add("inc_bounce", 0, (k < 10) && (k % 2 == 0), 0, 0, 0, 2'b00);
    // simultaneous presses cancel; inc's repeat (if enabled) lands alone later
    for (int k = 0; k < 20; k++) add("both_press", 0, 1, 1, 0, 0, k >= 6 ? 2'b11 : 2'b00);
    for (int k = 0; k < 6; k++)  add("inc_only", 0, 1, 0, AR && (k == 3), 0, 2'b11);
    for (int k = 0; k < 8; k++)  add("both_release", 0, 0, 0, 0, 0, k < 6 ? 2'b01 : 2'b00);
    for (int k = 0; k < 10; k++) add("dec_hold", 0, 0, 1, 0, k == 7, k >= 6 ? 2'b10 : 2'b00);
    for (int k = 0; k < 10; k++) add("inc_while_dec", 0, 1, 1, k == 7, 0, k >= 6 ? 2'b11 : 2'b10);
    for (int k = 0; k < 8; k++)  add("hold_release", 0, 0, 0, 0, 0, k < 6 ? 2'b11 : 2'b00);
    for (int k = 0; k < 4; k++)  add("rst_debounce", 0, 1, 0, 0, 0, 2'b00);
    add("rst_debounce", 1, 0, 0, 0, 0, 2'b00);
    for (int k = 0; k < 10; k++) add("rst_debounce", 0, 0, 0, 0, 0, 2'b00);
    for (int k = 0; k < 10; k++) add("rst_pressed", 0, 1, 0, k == 7, 0, k >= 6 ? 2'b01 : 2'b00);
    add("rst_pressed", 1, 1, 0, 0, 0, 2'b00);
    for (int k = 0; k < 12; k++) add("after_rst", 0, 1, 0, k == 7, 0, k >= 6 ? 2'b01 : 2'b00);
    for (int k = 0; k < 8; k++)  add("after_rst_rel", 0, 0, 0, 0, 0, k < 6 ? 2'b01 : 2'b00);
    for (int k = 0; k < 60; k++)
      add("long_hold", 0, 1, 0, (k == 7) || (AR && (k == 23 || k == 31 || k == 39 || k == 47 || k == 55)),
          0, k >= 6 ? 2'b01 : 2'b00);
    for (int k = 0; k < 8; k++)  add("long_release", 0, 0, 0, 0, 0, k < 6 ? 2'b01 : 2'b00);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst;
      inc = vecs[i].inc;
      dec = vecs[i].dec;
      @(posedge clk);
      #1;
      check(vecs[i].name, i, uo_inc_pulse, uo_dec_pulse, uo_held,
            vecs[i].exp_inc, vecs[i].exp_dec, vecs[i].exp_held);
    end

    // dec press latency measured with a bounded wait
    dec = 1'b1;
    found = 1'b0;
    lat = -1;
    for (int c = 0; c < 30 && !found; c++) begin
      @(posedge clk);
      #1;
      if (uo_dec_pulse) begin
        found = 1'b1;
        lat = c;
      end
    end
    n_vec++;
    if (!found || lat != int'(DEB + 3)) begin
      n_bad++;
      $display("FAIL dec_latency: got %0d edges (found=%0b), expected %0d", lat, found, DEB + 3);
    end

    dec = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(posedge clk);
      #1;
      if (uo_held == 2'b00) found = 1'b1;
    end
    n_vec++;
    if (!found) begin
      n_bad++;
      $display("FAIL dec_release_timeout: held=%b, expected 00 within 20 cycles", uo_held);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
